// File: rtl/lfsr_error_injector.sv
// lfsr_error_injector: injects single-bit errors into a valid/ready stream.
// The corrupted bit position and the trigger decision both come from the
// external LFSR word. The LFSR is stepped once per accepted input word.
// A triggered event can corrupt a burst of consecutive words.
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready.
// in_ready = !out_valid || out_ready. out_valid holds until out_ready is
// seen, and out_data/out_err stay stable while out_valid && !out_ready.
module lfsr_error_injector #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [31:0]       threshold,
    input  logic [7:0]        burst_len,
    input  logic [31:0]       rand_in,
    output logic              rand_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic [31:0]       word_count,
    output logic [31:0]       err_count,
    // Debug visibility of the burst state machine
    output logic              dbg_state_o,
    output logic [7:0]        dbg_burst_rem_o
);

    localparam int POS_W = $clog2(DATA_W);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        burst_rem_q, burst_rem_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_err_q, out_err_d;
    logic [31:0]       word_count_q, word_count_d;
    logic [31:0]       err_count_q, err_count_d;

    logic              transfer;
    logic              hit;
    logic              corrupt;
    logic [7:0]        burst_eff;
    logic [DATA_W-1:0] mask;

    // Handshake and LFSR step enable
    assign in_ready = !out_valid_q || out_ready;
    assign transfer = in_valid && in_ready;
    assign rand_en  = transfer && !rst;

    // Trigger decision and one-hot flip mask from the current LFSR word
    assign hit       = enable && (rand_in < threshold);
    assign burst_eff = (burst_len == 8'd0) ? 8'd1 : burst_len;
    assign mask      = {{(DATA_W-1){1'b0}}, 1'b1} << rand_in[POS_W-1:0];

    // Burst state machine: next state and corrupt decision, only on transfer
    always_comb begin
        state_d     = state_q;
        burst_rem_d = burst_rem_q;
        corrupt     = 1'b0;
        if (transfer) begin
            case (state_q)
                ST_IDLE: begin
                    if (hit) begin
                        corrupt = 1'b1;
                        if (burst_eff > 8'd1) begin
                            burst_rem_d = burst_eff - 8'd1;
                            state_d     = ST_BURST;
                        end
                    end
                end
                ST_BURST: begin
                    if (enable) begin
                        corrupt     = 1'b1;
                        burst_rem_d = burst_rem_q - 8'd1;
                        if (burst_rem_q == 8'd1) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        burst_rem_d = 8'd0;
                        state_d     = ST_IDLE;
                    end
                end
                default: begin
                    burst_rem_d = 8'd0;
                    state_d     = ST_IDLE;
                end
            endcase
        end
    end

    // Output register and saturating counters, next-state values
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_err_d    = out_err_q;
        word_count_d = word_count_q;
        err_count_d  = err_count_q;
        if (transfer) begin
            out_valid_d = 1'b1;
            out_data_d  = corrupt ? (in_data ^ mask) : in_data;
            out_err_d   = corrupt;
            if (word_count_q != 32'hFFFF_FFFF) begin
                word_count_d = word_count_q + 32'd1;
            end
            if (corrupt && (err_count_q != 32'hFFFF_FFFF)) begin
                err_count_d = err_count_q + 32'd1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State, output and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            burst_rem_q  <= 8'd0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_err_q    <= 1'b0;
            word_count_q <= 32'd0;
            err_count_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            burst_rem_q  <= burst_rem_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_err_q    <= out_err_d;
            word_count_q <= word_count_d;
            err_count_q  <= err_count_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;
    assign out_err         = out_err_q;
    assign word_count      = word_count_q;
    assign err_count       = err_count_q;
    assign dbg_state_o     = state_q;
    assign dbg_burst_rem_o = burst_rem_q;

endmodule

// File: tb/tb_lfsr_error_injector.sv
// Directed testbench for lfsr_error_injector. A counting stand-in replaces
// the LFSR so rand_in runs 0,1,2,... from reset, one step per rand_en.
module tb_lfsr_error_injector;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [31:0] threshold;
    logic [7:0]  burst_len;
    logic [31:0] rand_in;
    logic        rand_en;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;
    logic [31:0] word_count;
    logic [31:0] err_count;
    logic        dbg_state;
    logic [7:0]  dbg_burst_rem;

    int pass_cnt;
    int total_cnt;
    int rand_cnt;

    logic [31:0] exp_q[$];
    logic        exp_err_q[$];
    logic [31:0] got_q[$];
    logic        got_err_q[$];

    lfsr_error_injector #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .enable(enable), .threshold(threshold),
        .burst_len(burst_len), .rand_in(rand_in), .rand_en(rand_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .word_count(word_count), .err_count(err_count),
        .dbg_state_o(dbg_state), .dbg_burst_rem_o(dbg_burst_rem)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stand-in LFSR: simple counter stepped by rand_en
    always @(posedge clk) begin
        if (rst) rand_in <= 32'd0;
        else if (rand_en) rand_in <= rand_in + 32'd1;
    end

    // monitor: record accepted output words and rand_en pulses mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                got_err_q.push_back(out_err);
            end
            if (rand_en) rand_cnt++;
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        got_q.delete();
        got_err_q.delete();
        exp_q.delete();
        exp_err_q.delete();
        rand_cnt = 0;
    endtask

    task automatic send_words(input int n, input logic [31:0] data);
        in_data = data;
        in_valid = 1'b1;
        for (int i = 0; i < n; i++) step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        @(negedge clk);
        total_cnt++;
        if ({out_valid, out_data, out_err} !== 34'd0) $display("FAIL reset_out: got v=%0b d=%h e=%0b want 0", out_valid, out_data, out_err);
        else pass_cnt++;
        total_cnt++;
        if ({word_count, err_count} !== 64'd0) $display("FAIL reset_counts: got wc=%0d ec=%0d want 0", word_count, err_count);
        else pass_cnt++;
        total_cnt++;
        if ({dbg_state, dbg_burst_rem} !== 9'd0) $display("FAIL reset_state: got st=%0b rem=%0d want 0", dbg_state, dbg_burst_rem);
        else pass_cnt++;
        total_cnt++;
        if (rand_en !== 1'b0) $display("FAIL reset_rand_en: got %0b want 0", rand_en);
        else pass_cnt++;
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_zero_threshold();
        do_reset();
        threshold = 32'd0; enable = 1'b1; burst_len = 8'd1; out_ready = 1'b1;
        send_words(10, 32'hA5A5_A5A5);
        drain();
        total_cnt++;
        if (got_q.size() !== 10) $display("FAIL zero_thr_count: got %0d words want 10", got_q.size());
        else pass_cnt++;
        for (int i = 0; i < got_q.size(); i++) begin
            total_cnt++;
            if (got_q[i] !== 32'hA5A5_A5A5 || got_err_q[i] !== 1'b0)
                $display("FAIL zero_thr_word%0d: got %h err=%0b want a5a5a5a5 err=0", i, got_q[i], got_err_q[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (word_count !== 32'd10 || err_count !== 32'd0) $display("FAIL zero_thr_counters: got wc=%0d ec=%0d want 10/0", word_count, err_count);
        else pass_cnt++;
        total_cnt++;
        if (rand_cnt !== 10) $display("FAIL zero_thr_rand_en: got %0d pulses want 10", rand_cnt);
        else pass_cnt++;
    endtask

    task automatic test_full_threshold();
        do_reset();
        threshold = 32'hFFFF_FFFF; enable = 1'b1; burst_len = 8'd1; out_ready = 1'b1;
        exp_q = '{32'h1, 32'h2, 32'h4};
        exp_err_q = '{1'b1, 1'b1, 1'b1};
        in_data = 32'd0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++;
            if (dbg_state !== 1'b0) $display("FAIL full_thr_state%0d: got %0b want 0", i, dbg_state);
            else pass_cnt++;
        end
        drain();
        total_cnt++;
        if (got_q.size() !== 3) $display("FAIL full_thr_count: got %0d words want 3", got_q.size());
        else pass_cnt++;
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            total_cnt++;
            if (got_q[i] !== exp_q[i] || got_err_q[i] !== exp_err_q[i])
                $display("FAIL full_thr_word%0d: got %h err=%0b want %h err=%0b", i, got_q[i], got_err_q[i], exp_q[i], exp_err_q[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (err_count !== 32'd3) $display("FAIL full_thr_err_count: got %0d want 3", err_count);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        do_reset();
        threshold = 32'd0; enable = 1'b1; burst_len = 8'd1; out_ready = 1'b1;
        in_data = 32'h100; in_valid = 1'b1;
        step();
        out_ready = 1'b0;
        in_data = 32'h101;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total_cnt++;
            if (in_ready !== 1'b0 || rand_en !== 1'b0)
                $display("FAIL bp_stall%0d: got in_ready=%0b rand_en=%0b want 0/0", i, in_ready, rand_en);
            else pass_cnt++;
            total_cnt++;
            if (out_valid !== 1'b1 || out_data !== 32'h100 || word_count !== 32'd1)
                $display("FAIL bp_hold%0d: got v=%0b d=%h wc=%0d want 1/100/1", i, out_valid, out_data, word_count);
            else pass_cnt++;
            step();
        end
        out_ready = 1'b1;
        step();
        in_data = 32'h102;
        step();
        in_data = 32'h103;
        step();
        drain();
        exp_q = '{32'h100, 32'h101, 32'h102, 32'h103};
        total_cnt++;
        if (got_q.size() !== 4) $display("FAIL bp_count: got %0d words want 4", got_q.size());
        else pass_cnt++;
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            total_cnt++;
            if (got_q[i] !== exp_q[i]) $display("FAIL bp_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (word_count !== 32'd4 || rand_cnt !== 4) $display("FAIL bp_totals: got wc=%0d rand=%0d want 4/4", word_count, rand_cnt);
        else pass_cnt++;
    endtask

    task automatic test_burst();
        do_reset();
        threshold = 32'd1; enable = 1'b1; burst_len = 8'd4; out_ready = 1'b1;
        in_data = 32'd0; in_valid = 1'b1;
        step();
        total_cnt++;
        if (dbg_state !== 1'b1 || dbg_burst_rem !== 8'd3)
            $display("FAIL burst_start: got st=%0b rem=%0d want 1/3", dbg_state, dbg_burst_rem);
        else pass_cnt++;
        burst_len = 8'd7;
        for (int i = 0; i < 5; i++) step();
        drain();
        exp_q = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h0, 32'h0};
        exp_err_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        total_cnt++;
        if (got_q.size() !== 6) $display("FAIL burst_count: got %0d words want 6", got_q.size());
        else pass_cnt++;
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            total_cnt++;
            if (got_q[i] !== exp_q[i] || got_err_q[i] !== exp_err_q[i])
                $display("FAIL burst_word%0d: got %h err=%0b want %h err=%0b", i, got_q[i], got_err_q[i], exp_q[i], exp_err_q[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (err_count !== 32'd4 || dbg_state !== 1'b0)
            $display("FAIL burst_end: got ec=%0d st=%0b want 4/0", err_count, dbg_state);
        else pass_cnt++;
    endtask

    task automatic test_abort_enable();
        do_reset();
        threshold = 32'd1; enable = 1'b1; burst_len = 8'd4; out_ready = 1'b1;
        send_words(2, 32'd0);
        enable = 1'b0;
        send_words(1, 32'd0);
        total_cnt++;
        if (dbg_state !== 1'b0 || dbg_burst_rem !== 8'd0)
            $display("FAIL abort_en_state: got st=%0b rem=%0d want 0/0", dbg_state, dbg_burst_rem);
        else pass_cnt++;
        send_words(3, 32'd0);
        drain();
        exp_q = '{32'h1, 32'h2, 32'h0, 32'h0, 32'h0, 32'h0};
        exp_err_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        total_cnt++;
        if (got_q.size() !== 6) $display("FAIL abort_en_count: got %0d words want 6", got_q.size());
        else pass_cnt++;
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            total_cnt++;
            if (got_q[i] !== exp_q[i] || got_err_q[i] !== exp_err_q[i])
                $display("FAIL abort_en_word%0d: got %h err=%0b want %h err=%0b", i, got_q[i], got_err_q[i], exp_q[i], exp_err_q[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (err_count !== 32'd2) $display("FAIL abort_en_err_count: got %0d want 2", err_count);
        else pass_cnt++;
        enable = 1'b1;
    endtask

    task automatic test_abort_reset();
        do_reset();
        threshold = 32'd1; enable = 1'b1; burst_len = 8'd4; out_ready = 1'b0;
        in_data = 32'd0; in_valid = 1'b1;
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total_cnt++;
        if (dbg_state !== 1'b1 || dbg_burst_rem !== 8'd2 || out_valid !== 1'b1)
            $display("FAIL abort_rst_pre: got st=%0b rem=%0d v=%0b want 1/2/1", dbg_state, dbg_burst_rem, out_valid);
        else pass_cnt++;
        rst = 1'b1;
        step();
        @(negedge clk);
        total_cnt++;
        if ({out_valid, out_data, out_err} !== 34'd0) $display("FAIL abort_rst_out: got v=%0b d=%h e=%0b want 0", out_valid, out_data, out_err);
        else pass_cnt++;
        total_cnt++;
        if ({word_count, err_count} !== 64'd0) $display("FAIL abort_rst_counts: got wc=%0d ec=%0d want 0", word_count, err_count);
        else pass_cnt++;
        total_cnt++;
        if ({dbg_state, dbg_burst_rem, rand_en} !== 10'd0) $display("FAIL abort_rst_state: got st=%0b rem=%0d ren=%0b want 0", dbg_state, dbg_burst_rem, rand_en);
        else pass_cnt++;
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_burst_len_zero();
        do_reset();
        threshold = 32'hFFFF_FFFF; enable = 1'b1; burst_len = 8'd0; out_ready = 1'b1;
        in_data = 32'd0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total_cnt++;
            if (dbg_state !== 1'b0) $display("FAIL bl0_state%0d: got %0b want 0", i, dbg_state);
            else pass_cnt++;
        end
        drain();
        exp_q = '{32'h1, 32'h2, 32'h4, 32'h8};
        total_cnt++;
        if (got_q.size() !== 4) $display("FAIL bl0_count: got %0d words want 4", got_q.size());
        else pass_cnt++;
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            total_cnt++;
            if (got_q[i] !== exp_q[i] || got_err_q[i] !== 1'b1)
                $display("FAIL bl0_word%0d: got %h err=%0b want %h err=1", i, got_q[i], got_err_q[i], exp_q[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (err_count !== 32'd4) $display("FAIL bl0_err_count: got %0d want 4", err_count);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0; rand_cnt = 0;
        rst = 1'b1; enable = 1'b0; threshold = 32'd0; burst_len = 8'd1;
        in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b1;
        test_reset();
        test_zero_threshold();
        test_full_threshold();
        test_backpressure();
        test_burst();
        test_abort_enable();
        test_abort_reset();
        test_burst_len_zero();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // global time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/lfsr_error_injector.md
Name: lfsr_error_injector

Overview:
- Consumes the 32-bit pseudo-random word from the LFSR stage and uses it to inject single-bit errors into a valid/ready data stream at a programmable rate.
- Drives the LFSR clock enable so the LFSR advances exactly once per accepted data word.
- Supports burst errors, where one triggered event corrupts N consecutive words, and maintains word and error counters for BER measurement.

Parameters:
- DATA_W, 32: data word width; must be a power of two, 2..32.
- POS_W, derived localparam clog2(DATA_W): number of random bits used to select the flipped bit.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  injection enable; 0 = pass-through, still counts words.
- threshold  in  32  error trigger threshold; hit when rand_in < threshold (unsigned).
- burst_len  in  8  words corrupted per event; 0 treated as 1.
- rand_in  in  32  current LFSR output.
- rand_en  out  1  LFSR clock enable; one pulse per accepted word.
- in_valid  in  1  upstream data valid.
- in_ready  out  1  block can accept a word.
- in_data  in  DATA_W  upstream data.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  possibly corrupted data.
- out_err  out  1  out_data was corrupted.
- word_count  out  32  accepted words, saturating.
- err_count  out  32  corrupted words, saturating.

Behaviour:
- Reset, synchronous and active-high: out_valid=0, out_data=0, out_err=0, word_count=0, err_count=0, state=IDLE, burst_rem=0. rand_en is 0 while rst=1.
- Handshake: single output register.
  - in_ready = !out_valid || out_ready (combinational).
  - Transfer occurs when in_valid && in_ready.
  - Latency is 1 cycle: the word is presented on out_data the cycle after transfer.
  - out_valid clears when out_ready=1 and no new transfer occurs.
  - While out_valid=1 and out_ready=0, out_data and out_err are held stable.
- rand_en = in_valid && in_ready && !rst (combinational).
  - The rand_in value sampled at the transfer edge is the one used for that word.
  - The LFSR advances on that same edge.
- Corruption mask: a one-hot vector with bit rand_in[POS_W-1:0] set. out_data = in_data ^ mask when the word is corrupted, otherwise in_data.
- State machine, evaluated only on a transfer:
  - IDLE:
    - hit = enable && (rand_in < threshold).
    - If hit: corrupt the word. If effective burst_len > 1, load burst_rem = burst_len-1 and go to BURST.
    - If no hit: pass the word through.
  - BURST:
    - If enable=1: corrupt the word unconditionally and decrement burst_rem; return to IDLE when burst_rem reaches 0.
    - If enable=0: abort, pass the word through, burst_rem=0, go to IDLE.
  - burst_len is sampled only at burst start; changes mid-burst are ignored.
- Threshold boundaries:
  - threshold=0: never hit.
  - threshold=0xFFFFFFFF: every word hits. The XNOR LFSR never produces the all-ones word.
- Counters:
  - word_count increments on every transfer.
  - err_count increments on every corrupted transfer.
  - Both saturate at 0xFFFFFFFF.
- Reset mid-burst aborts the burst, drops any held output word, and restores all reset values.
- No transfer means no state, counter or LFSR change.

Test Plan:
- Zero threshold: rst, then threshold=0, enable=1, stream 10 words 0xA5A5A5A5 with out_ready=1 -> all outputs 0xA5A5A5A5, out_err=0, word_count=10, err_count=0, 10 rand_en pulses.
- Full threshold: threshold=0xFFFFFFFF, burst_len=1, LFSR reset alongside, in_data=0 x3 -> out_data = 0x00000001, 0x00000002, 0x00000004 (rand_in 0, 1, 2); out_err=1 each; err_count=3.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, rand_en=0, out_data stable, word_count unchanged. Then release -> exactly one transfer per cycle resumes with no word lost or duplicated.
- Burst: threshold=1, burst_len=4, enable=1 after reset, stream 6 words -> word 1 hits (rand_in=0); words 1-4 corrupted, words 5-6 clean; err_count=4.
- Abort cases:
  - Same burst setup, enable dropped after word 2 -> words 3+ clean, state IDLE.
  - Repeat with rst pulsed after word 2 -> all outputs, counters and burst_rem are 0 the next cycle.
- burst_len=0 with threshold=0xFFFFFFFF -> each word corrupted independently, behaving as burst_len=1; the state machine never enters BURST.
